// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single game memory port between two requesters
//   (P0 = GameProcessor, P1 = system/loader processor). Each requester uses
//   a REQ/ACK handshake; accesses are serialised with round-robin
//   arbitration and driven onto the memory controller interface.
//
// Optional feature:
//   `define MEM_ARB_LOCK_EN adds P0_LOCK/P1_LOCK. A winner that holds LOCK
//   high in its DONE cycle keeps ownership for the next IDLE if it is still
//   requesting. The default build (macro undefined) is pure round-robin.
//
// Parameters:
//   RD_LAT  cycles from the MEM_ENABLE cycle to valid MEM_DATA_R (1..7)
//   ADDR_W  address width
//   DATA_W  data width
//
// Ports:
//   CLK, RESET_N           clock, asynchronous active-low reset
//   ENABLE                 grant enable (in-flight access always completes)
//   Px_REQ/WRITE/ADDR/WDATA requester inputs, held stable until Px_ACK
//   Px_LOCK                lock request (only with MEM_ARB_LOCK_EN)
//   Px_ACK                 one-cycle completion pulse
//   Px_RDATA               last read data for that requester
//   GRANT                  one-hot owner of the access in flight, 00 idle
//   BUSY                   high whenever the FSM is not in IDLE
//   MEM_ENABLE/WRITE/ADDR/DATA_W  memory controller request
//   MEM_DATA_R             memory read data, valid RD_LAT cycles after strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              P0_REQ,
    input  logic              P0_WRITE,
    input  logic [ADDR_W-1:0] P0_ADDR,
    input  logic [DATA_W-1:0] P0_WDATA,
    input  logic              P1_REQ,
    input  logic              P1_WRITE,
    input  logic [ADDR_W-1:0] P1_ADDR,
    input  logic [DATA_W-1:0] P1_WDATA,
`ifdef MEM_ARB_LOCK_EN
    input  logic              P0_LOCK,
    input  logic              P1_LOCK,
`endif
    output logic              P0_ACK,
    output logic [DATA_W-1:0] P0_RDATA,
    output logic              P1_ACK,
    output logic [DATA_W-1:0] P1_RDATA,
    output logic [1:0]        GRANT,
    output logic              BUSY,
    output logic              MEM_ENABLE,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA_W,
    input  logic [DATA_W-1:0] MEM_DATA_R
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Terminal value of the read-latency counter (counter starts at 0).
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    // -----------------------------------------------------------------------
    // Requester inputs gathered into index-able form (index = port number).
    // -----------------------------------------------------------------------
    logic [1:0]        req_vec;
    logic [1:0]        write_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];

    assign req_vec      = {P1_REQ, P0_REQ};
    assign write_vec    = {P1_WRITE, P0_WRITE};
    assign addr_arr[0]  = P0_ADDR;
    assign addr_arr[1]  = P1_ADDR;
    assign wdata_arr[0] = P0_WDATA;
    assign wdata_arr[1] = P1_WDATA;

`ifdef MEM_ARB_LOCK_EN
    logic [1:0] lock_vec;
    assign lock_vec = {P1_LOCK, P0_LOCK};
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_reg;
    logic [2:0]        cnt_reg;
    logic              owner_reg;       // port number of the access in flight
    logic              last_reg;        // port number of the most recent winner
    logic [1:0]        grant_reg;
    logic              busy_reg;
    logic              mem_enable_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_data_w_reg;
    logic [1:0]        ack_reg;
`ifdef MEM_ARB_LOCK_EN
    logic              locked_reg;      // owner is always last_reg while set
`endif

    // -----------------------------------------------------------------------
    // Winner selection, evaluated only while in IDLE.
    // A lone requester wins outright; a tie goes to the port that did not
    // win last time. An active lock overrides both rules.
    // -----------------------------------------------------------------------
    logic win_next;
    logic start_grant;

    always_comb begin
        win_next = 1'b0;
        if (req_vec == 2'b11) begin
            win_next = ~last_reg;
        end else begin
            win_next = req_vec[1];
        end
`ifdef MEM_ARB_LOCK_EN
        if (locked_reg && req_vec[last_reg]) begin
            win_next = last_reg;
        end
`endif
    end

    assign start_grant = ENABLE && (|req_vec);

    // Final WAIT edge: memory data is valid and is captured for the owner.
    logic rd_capture;
    assign rd_capture = (state_reg == WAIT) && (cnt_reg == LAT_LAST);

    // -----------------------------------------------------------------------
    // Main FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_reg       <= 1'b1;         // P0 wins the first tie
            grant_reg      <= '0;
            busy_reg       <= 1'b0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_w_reg <= '0;
            ack_reg        <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                    // The lock lapses as soon as its owner stops requesting.
                    if (locked_reg && !req_vec[last_reg]) begin
                        locked_reg <= 1'b0;
                    end
`endif
                    if (start_grant) begin
                        state_reg      <= ISSUE;
                        busy_reg       <= 1'b1;
                        mem_enable_reg <= 1'b1;
                        mem_write_reg  <= write_vec[win_next];
                        mem_addr_reg   <= addr_arr[win_next];
                        mem_data_w_reg <= wdata_arr[win_next];
                        grant_reg      <= win_next ? 2'b10 : 2'b01;
                        owner_reg      <= win_next;
                        last_reg       <= win_next;
                    end
                end

                ISSUE: begin
                    // Strobe is a single-cycle pulse.
                    mem_enable_reg <= 1'b0;
                    if (mem_write_reg) begin
                        state_reg <= DONE;
                        ack_reg   <= owner_reg ? 2'b10 : 2'b01;
                    end else begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                    end
                end

                WAIT: begin
                    if (cnt_reg == LAT_LAST) begin
                        state_reg <= DONE;
                        ack_reg   <= owner_reg ? 2'b10 : 2'b01;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end

                DONE: begin
                    state_reg      <= IDLE;
                    ack_reg        <= '0;
                    busy_reg       <= 1'b0;
                    grant_reg      <= '0;
                    mem_write_reg  <= 1'b0;
                    mem_addr_reg   <= '0;
                    mem_data_w_reg <= '0;
`ifdef MEM_ARB_LOCK_EN
                    locked_reg     <= lock_vec[owner_reg];
`endif
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-requester read-data registers. Only a completed read of that
    // requester updates its register; writes leave it untouched.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                rdata_reg <= '0;
            end else if (rd_capture && (owner_reg == 1'(gi))) begin
                rdata_reg <= MEM_DATA_R;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign P0_ACK     = ack_reg[0];
    assign P1_ACK     = ack_reg[1];
    assign P0_RDATA   = g_port[0].rdata_reg;
    assign P1_RDATA   = g_port[1].rdata_reg;
    assign GRANT      = grant_reg;
    assign BUSY       = busy_reg;
    assign MEM_ENABLE = mem_enable_reg;
    assign MEM_WRITE  = mem_write_reg;
    assign MEM_ADDR   = mem_addr_reg;
    assign MEM_DATA_W = mem_data_w_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances (RD_LAT=1 and RD_LAT=4) share one clock. Every
// cycle the outputs of the instance under test are compared with a
// transaction-level reference model: a grant decided in IDLE cycle t puts
// the access on the bus from t+1 up to its ACK cycle (t+2 for writes,
// t+RD_LAT+2 for reads). Directed table rows and hand-written sequences
// add explicit checks for latency, alternation, ENABLE, reset and lock.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [2];
    logic        en       [2];
    logic        req      [2][2];
    logic        wr       [2][2];
    logic [15:0] addr     [2][2];
    logic [15:0] wdata    [2][2];
`ifdef MEM_ARB_LOCK_EN
    logic        lk       [2][2];
`endif
    logic        ack      [2][2];
    logic [15:0] rdata    [2][2];
    logic [1:0]  grant    [2];
    logic        busy     [2];
    logic        mem_en   [2];
    logic        mem_wr   [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_dw   [2];
    logic [15:0] mem_dr   [2];

    mem_arbiter #(.RD_LAT(LAT0), .ADDR_W(16), .DATA_W(16)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n[0]), .ENABLE(en[0]),
        .P0_REQ(req[0][0]), .P0_WRITE(wr[0][0]), .P0_ADDR(addr[0][0]), .P0_WDATA(wdata[0][0]),
        .P1_REQ(req[0][1]), .P1_WRITE(wr[0][1]), .P1_ADDR(addr[0][1]), .P1_WDATA(wdata[0][1]),
`ifdef MEM_ARB_LOCK_EN
        .P0_LOCK(lk[0][0]), .P1_LOCK(lk[0][1]),
`endif
        .P0_ACK(ack[0][0]), .P0_RDATA(rdata[0][0]),
        .P1_ACK(ack[0][1]), .P1_RDATA(rdata[0][1]),
        .GRANT(grant[0]), .BUSY(busy[0]),
        .MEM_ENABLE(mem_en[0]), .MEM_WRITE(mem_wr[0]), .MEM_ADDR(mem_addr[0]),
        .MEM_DATA_W(mem_dw[0]), .MEM_DATA_R(mem_dr[0])
    );

    mem_arbiter #(.RD_LAT(LAT1), .ADDR_W(16), .DATA_W(16)) u_dut1 (
        .CLK(clk), .RESET_N(rst_n[1]), .ENABLE(en[1]),
        .P0_REQ(req[1][0]), .P0_WRITE(wr[1][0]), .P0_ADDR(addr[1][0]), .P0_WDATA(wdata[1][0]),
        .P1_REQ(req[1][1]), .P1_WRITE(wr[1][1]), .P1_ADDR(addr[1][1]), .P1_WDATA(wdata[1][1]),
`ifdef MEM_ARB_LOCK_EN
        .P0_LOCK(lk[1][0]), .P1_LOCK(lk[1][1]),
`endif
        .P0_ACK(ack[1][0]), .P0_RDATA(rdata[1][0]),
        .P1_ACK(ack[1][1]), .P1_RDATA(rdata[1][1]),
        .GRANT(grant[1]), .BUSY(busy[1]),
        .MEM_ENABLE(mem_en[1]), .MEM_WRITE(mem_wr[1]), .MEM_ADDR(mem_addr[1]),
        .MEM_DATA_W(mem_dw[1]), .MEM_DATA_R(mem_dr[1])
    );

    // Memory contents as a pure function of address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5555);
    endfunction

    // Memory controller model: data is valid only exactly RD_LAT cycles
    // after the strobe cycle, garbage otherwise.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mem
        localparam int LAT = (gi == 0) ? LAT0 : LAT1;
        logic [7:0]  en_hist = '0;
        logic [15:0] addr_hist [8];
        always @(posedge clk) begin
            en_hist      <= {en_hist[6:0], mem_en[gi]};
            addr_hist[0] <= mem_addr[gi];
            for (int i = 1; i < 8; i++) addr_hist[i] <= addr_hist[i-1];
        end
        assign mem_dr[gi] = en_hist[LAT-1] ? memf(addr_hist[LAT-1]) : 16'hDEAD;
    end

    // ---------------------------------------------------------------------
    // Reference model (transaction schedule)
    // ---------------------------------------------------------------------
    int          checks;
    int          failures;
    int          cyc;
    bit          t_valid;
    int          t_start;
    int          t_ack;
    bit          t_owner;
    bit          t_write;
    logic [15:0] t_addr;
    logic [15:0] t_wdata;
    bit          last;
    logic [15:0] exp_rd [2];
    bit          locked;

    task automatic model_reset();
        t_valid   = 1'b0;
        last      = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        locked    = 1'b0;
    endtask

    function automatic bit model_ack(input int p);
        return t_valid && (cyc == t_ack) && (int'(t_owner) == p);
    endfunction

    function automatic logic [70:0] got_vec(input int k);
        return {grant[k], busy[k], mem_en[k], mem_wr[k], mem_addr[k], mem_dw[k],
                ack[k][1], ack[k][0], rdata[k][1], rdata[k][0]};
    endfunction

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Wait for mid-cycle and compare the whole output bundle with the model.
    task automatic begin_cycle(input int k);
        bit          act;
        logic [70:0] exp;
        @(negedge clk);
        act = t_valid && (cyc >= t_start) && (cyc <= t_ack);
        if (act && (cyc == t_ack) && !t_write) exp_rd[t_owner] = memf(t_addr);
        exp = {act ? (t_owner ? 2'b10 : 2'b01) : 2'b00,
               act, act && (cyc == t_start), act && t_write,
               act ? t_addr : 16'h0000, act ? t_wdata : 16'h0000,
               act && (cyc == t_ack) && t_owner, act && (cyc == t_ack) && !t_owner,
               exp_rd[1], exp_rd[0]};
        chk($sformatf("outputs_inst%0d", k), {9'd0, got_vec(k)}, {9'd0, exp});
    endtask

    // Inputs for this cycle are final: apply the arbitration rules.
    task automatic end_cycle(input int k);
        bit w;
        int lat;
        lat = (k == 0) ? LAT0 : LAT1;
`ifdef MEM_ARB_LOCK_EN
        if (t_valid && (cyc == t_ack)) locked = lk[k][t_owner];
`endif
        if (!(t_valid && (cyc <= t_ack))) begin
            if (locked && !req[k][last]) locked = 1'b0;
            if (en[k] && (req[k][0] || req[k][1])) begin
                if (locked && req[k][last]) w = last;
                else if (req[k][0] && req[k][1]) w = !last;
                else w = req[k][1];
                last    = w;
                t_valid = 1'b1;
                t_owner = w;
                t_write = wr[k][w];
                t_addr  = addr[k][w];
                t_wdata = wdata[k][w];
                t_start = cyc + 1;
                t_ack   = t_write ? cyc + 2 : cyc + lat + 2;
            end
        end
        cyc++;
    endtask

    // Called mid-cycle: assert reset asynchronously, hold it two cycles.
    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        #1;
        chk($sformatf("async_reset_inst%0d", k), {9'd0, got_vec(k)}, 80'd0);
        model_reset();
        cyc++;
        begin_cycle(k);
        cyc++;
        begin_cycle(k);
        rst_n[k] = 1'b1;
        end_cycle(k);
    endtask

    // Let outstanding requests complete and the arbiter return to IDLE.
    task automatic drain(input int k);
        bit ok;
        ok    = 1'b0;
        en[k] = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            begin_cycle(k);
            for (int p = 0; p < 2; p++) if (model_ack(p)) req[k][p] = 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lk[k][0] = 1'b0;
            lk[k][1] = 1'b0;
`endif
            end_cycle(k);
            ok = !req[k][0] && !req[k][1] && !(t_valid && (cyc <= t_ack));
        end
        chk("drain_done", {79'd0, ok}, 80'd1);
    endtask

    task automatic new_req(input int k, input int p);
        req[k][p]   = 1'b1;
        wr[k][p]    = 1'($urandom_range(1, 0));
        addr[k][p]  = ($urandom_range(3, 0) == 0) ? 16'h0040 : 16'($urandom);
        wdata[k][p] = 16'($urandom);
    endtask

    task automatic rand_run(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle(k);
            for (int p = 0; p < 2; p++) begin
                if (req[k][p]) begin
                    if (model_ack(p)) begin
                        if ($urandom_range(1, 0) == 0) req[k][p] = 1'b0;
                        else new_req(k, p);
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    new_req(k, p);
                end
            end
            en[k] = ($urandom_range(7, 0) != 0);
            end_cycle(k);
        end
        drain(k);
    endtask

    // ---------------------------------------------------------------------
    // Directed single-access table (instance 0, RD_LAT=1)
    // ---------------------------------------------------------------------
    typedef struct {
        int          port;
        bit          write;
        logic [15:0] a;
        logic [15:0] d;
        int          ack_off;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          c0;
        int          p;
        int          ack_off;
        bit          issue_ok;
        bit          other_ack;
        logic [15:0] rd_got;
        logic [1:0]  seq [4];
        logic [1:0]  exp_seq [4];
        logic [1:0]  prev;
        int          ns;
        bit          quiet;

        tbl[0] = '{0, 1'b0, 16'h0040, 16'h0000, LAT0 + 2, 16'hBEEF};
        tbl[1] = '{1, 1'b1, 16'h1234, 16'h00A5, 2,        16'h0000};
        tbl[2] = '{1, 1'b0, 16'h1234, 16'h0000, LAT0 + 2, 16'h4761};
        tbl[3] = '{0, 1'b1, 16'h0040, 16'hFFFF, 2,        16'hBEEF};
        tbl[4] = '{0, 1'b0, 16'h0000, 16'h0000, LAT0 + 2, 16'h5555};
        tbl[5] = '{1, 1'b1, 16'h0040, 16'h0000, 2,        16'h4761};

        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            en[k]    = 1'b1;
            for (int q = 0; q < 2; q++) begin
                req[k][q]   = 1'b0;
                wr[k][q]    = 1'b0;
                addr[k][q]  = '0;
                wdata[k][q] = '0;
`ifdef MEM_ARB_LOCK_EN
                lk[k][q]    = 1'b0;
`endif
            end
        end
        model_reset();

        // ---------------- instance 0 ----------------
        begin_cycle(0);
        do_reset(0);

        for (int i = 0; i < 6; i++) begin
            begin_cycle(0);
            p           = tbl[i].port;
            req[0][p]   = 1'b1;
            wr[0][p]    = tbl[i].write;
            addr[0][p]  = tbl[i].a;
            wdata[0][p] = tbl[i].d;
            c0          = cyc;
            ack_off     = -1;
            issue_ok    = 1'b0;
            other_ack   = 1'b0;
            rd_got      = 16'hXXXX;
            end_cycle(0);
            for (int n = 0; n < 20 && ack_off < 0; n++) begin
                begin_cycle(0);
                if (mem_en[0] && (cyc == c0 + 1))
                    issue_ok = (mem_addr[0] == tbl[i].a) && (mem_wr[0] == tbl[i].write) &&
                               (!tbl[i].write || (mem_dw[0] == tbl[i].d));
                if (ack[0][1-p]) other_ack = 1'b1;
                if (ack[0][p]) begin
                    ack_off   = cyc - c0;
                    rd_got    = rdata[0][p];
                    req[0][p] = 1'b0;
                end
                end_cycle(0);
            end
            chk($sformatf("tbl%0d_ack_latency", i), 80'(ack_off), 80'(tbl[i].ack_off));
            chk($sformatf("tbl%0d_mem_issue", i), {79'd0, issue_ok}, 80'd1);
            chk($sformatf("tbl%0d_rdata", i), {64'd0, rd_got}, {64'd0, tbl[i].exp_rdata});
            chk($sformatf("tbl%0d_other_ack", i), {79'd0, other_ack}, 80'd0);
            begin_cycle(0);
            end_cycle(0);
        end

        // Both requesters held high from reset: grants alternate.
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        begin_cycle(0);
        for (int q = 0; q < 2; q++) begin
            req[0][q]   = 1'b1;
            wr[0][q]    = 1'b1;
            addr[0][q]  = 16'h0100 + 16'(q);
            wdata[0][q] = 16'h00F0 + 16'(q);
        end
        do_reset(0);
        ns   = 0;
        prev = 2'b00;
        for (int q = 0; q < 4; q++) seq[q] = 2'b00;
        for (int n = 0; n < 60 && ns < 4; n++) begin
            begin_cycle(0);
            if ((grant[0] != 2'b00) && (prev == 2'b00)) begin
                seq[ns] = grant[0];
                ns++;
            end
            prev = grant[0];
            end_cycle(0);
        end
        for (int q = 0; q < 4; q++)
            chk($sformatf("alternate_grant%0d", q), {78'd0, seq[q]}, {78'd0, exp_seq[q]});
        drain(0);

        // ENABLE low holds off a pending request; grant follows ENABLE rise.
        begin_cycle(0);
        en[0]       = 1'b0;
        req[0][0]   = 1'b1;
        wr[0][0]    = 1'b0;
        addr[0][0]  = 16'h0200;
        end_cycle(0);
        quiet = 1'b1;
        for (int n = 0; n < 10; n++) begin
            begin_cycle(0);
            if (busy[0] !== 1'b0 || mem_en[0] !== 1'b0) quiet = 1'b0;
            end_cycle(0);
        end
        chk("enable_low_quiet", {79'd0, quiet}, 80'd1);
        begin_cycle(0);
        en[0] = 1'b1;
        end_cycle(0);
        begin_cycle(0);
        chk("grant_after_enable", {78'd0, grant[0]}, 80'd1);
        en[0] = 1'b0;                       // access in flight must still complete
        end_cycle(0);
        for (int n = 0; n < 4; n++) begin
            begin_cycle(0);
            if (model_ack(0)) req[0][0] = 1'b0;
            end_cycle(0);
        end
        drain(0);

`ifdef MEM_ARB_LOCK_EN
        // P1 keeps LOCK for two DONEs: three P1 grants, then P0.
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
        begin_cycle(0);
        req[0][1]   = 1'b1;
        wr[0][1]    = 1'b1;
        addr[0][1]  = 16'h2000;
        wdata[0][1] = 16'h1111;
        lk[0][1]    = 1'b1;
        wr[0][0]    = 1'b1;
        addr[0][0]  = 16'h3000;
        wdata[0][0] = 16'h2222;
        end_cycle(0);
        begin : lock_seq
            int p1_acks;
            p1_acks = 0;
            ns      = 0;
            prev    = 2'b00;
            for (int q = 0; q < 4; q++) seq[q] = 2'b00;
            for (int n = 0; n < 80 && ns < 4; n++) begin
                begin_cycle(0);
                if ((grant[0] != 2'b00) && (prev == 2'b00)) begin
                    seq[ns] = grant[0];
                    ns++;
                end
                prev = grant[0];
                if (ns >= 1) req[0][0] = 1'b1;
                lk[0][1] = (p1_acks < 2);
                if (model_ack(1)) begin
                    p1_acks++;
                    if (p1_acks >= 3) req[0][1] = 1'b0;
                end
                if (model_ack(0)) req[0][0] = 1'b0;
                end_cycle(0);
            end
        end
        for (int q = 0; q < 4; q++)
            chk($sformatf("lock_grant%0d", q), {78'd0, seq[q]}, {78'd0, exp_seq[q]});
        drain(0);
`endif

        rand_run(0, 1500);

        // ---------------- instance 1 (RD_LAT=4) ----------------
        model_reset();
        begin_cycle(1);
        do_reset(1);
        rand_run(1, 1500);

        // Reset in the middle of a read wait: nothing acknowledged,
        // pending requests restart from IDLE with P0 priority.
        begin_cycle(1);
        req[1][0]   = 1'b1;
        wr[1][0]    = 1'b0;
        addr[1][0]  = 16'h0040;
        end_cycle(1);
        begin_cycle(1);                     // ISSUE
        end_cycle(1);
        begin_cycle(1);                     // first WAIT cycle
        end_cycle(1);
        begin_cycle(1);                     // second WAIT cycle
        chk("busy_in_wait", {79'd0, busy[1]}, 80'd1);
        req[1][1]   = 1'b1;
        wr[1][1]    = 1'b1;
        addr[1][1]  = 16'h0001;
        wdata[1][1] = 16'h0002;
        do_reset(1);
        prev = 2'b00;
        for (int n = 0; n < 10 && prev == 2'b00; n++) begin
            begin_cycle(1);
            prev = grant[1];
            end_cycle(1);
        end
        chk("grant_after_reset", {78'd0, prev}, 80'd1);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
